l2pa_page_wr_buffer: RTL and testbench

- Downstream stage of the two-level page-alignment interface (L1PA circular shift + L2PA).
- Collects page-aligned, bit-sliced message beats and packs PAGE_SLICES consecutive beats into one page-wide word.
- Writes completed pages to the shared message memory through a valid/ready write port with auto-incrementing page address.
- Two-entry page FIFO decouples the message-passing pipeline from memory backpressure.

---
 rtl/l2pa_page_wr_buffer.sv | 138 +++++++++++++
 tb/tb_l2pa_page_wr_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2pa_page_wr_buffer.sv
// Packs PAGE_SLICES aligned message beats into one page word and writes pages to the
// message memory through a two-entry FIFO with an auto-incrementing page address.
module l2pa_page_wr_buffer #(
  parameter int unsigned SHIFT_LENGTH    = 5,
  parameter int unsigned QUAN_SIZE       = 4,
  parameter int unsigned PAGE_SLICES     = 3,
  parameter int unsigned PAGE_ADDR_WIDTH = 6
) (
  input  logic                                      sys_clk,
  input  logic                                      rstn,
  input  logic [QUAN_SIZE*SHIFT_LENGTH-1:0]         msgIn_i,
  input  logic                                      msgIn_valid_i,
  output logic                                      msgIn_ready_o,
  input  logic                                      layer_start_i,
  input  logic [PAGE_ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [PAGE_ADDR_WIDTH-1:0]                page_num_i,
  output logic                                      mem_wr_en_o,
  input  logic                                      mem_wr_ready_i,
  output logic [PAGE_ADDR_WIDTH-1:0]                mem_wr_addr_o,
  output logic [PAGE_SLICES*QUAN_SIZE*SHIFT_LENGTH-1:0] mem_wr_data_o,
  output logic                                      layer_done_o,
  output logic                                      err_partial_o
);

  localparam int unsigned W  = QUAN_SIZE * SHIFT_LENGTH;
  localparam int unsigned PW = PAGE_SLICES * W;
  localparam int unsigned SW = (PAGE_SLICES > 1) ? $clog2(PAGE_SLICES) : 1;
  localparam logic [SW-1:0] LastSlice = SW'(PAGE_SLICES - 1);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                     state_q, state_d;
  logic [SW-1:0]              slice_q, slice_d, slice_eff;
  logic [PW-1:0]              asm_q, asm_d;
  logic [PAGE_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, addr_eff;
  logic [PAGE_ADDR_WIDTH-1:0] page_num_q, page_num_d;
  logic [PAGE_ADDR_WIDTH:0]   page_cnt_q, page_cnt_d, page_target;
  logic                       counting_q, counting_d;
  logic [PW-1:0]              fifo_data_q [2];
  logic [PAGE_ADDR_WIDTH-1:0] fifo_addr_q [2];
  logic                       wptr_q, rptr_q;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       ready_q, done_q, done_d, err_q, err_d;
  logic                       accept, push, pop;

  always_comb begin
    accept    = msgIn_valid_i && ready_q;
    // A beat arriving with layer_start_i already belongs to the new layer.
    slice_eff = layer_start_i ? '0 : slice_q;
    addr_eff  = layer_start_i ? base_addr_i : wr_addr_q;
    push      = accept && (slice_eff == LastSlice);
    pop       = (state_q == StWrite) && mem_wr_ready_i;

    asm_d = asm_q;
    if (accept) begin
      for (int i = 0; i < PAGE_SLICES; i++) begin
        if (slice_eff == SW'(i)) asm_d[i*W +: W] = msgIn_i;
      end
    end

    slice_d = slice_eff;
    if (accept) slice_d = push ? '0 : slice_eff + 1'b1;
    wr_addr_d = push ? addr_eff + 1'b1 : addr_eff;

    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
    state_d = (cnt_d != 2'd0) ? StWrite : StIdle;

    page_target = (page_num_q == '0) ? {1'b1, {PAGE_ADDR_WIDTH{1'b0}}} : {1'b0, page_num_q};
    page_cnt_d  = page_cnt_q;
    counting_d  = counting_q;
    page_num_d  = page_num_q;
    done_d      = 1'b0;
    err_d       = err_q;
    if (pop && counting_q) begin
      if (page_cnt_q + 1'b1 == page_target) begin
        done_d     = 1'b1;
        page_cnt_d = '0;
        counting_d = 1'b0;
      end else begin
        page_cnt_d = page_cnt_q + 1'b1;
      end
    end
    if (layer_start_i) begin
      page_num_d = page_num_i;
      page_cnt_d = '0;
      counting_d = 1'b1;
      if (slice_q != '0) err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      slice_q     <= '0;
      asm_q       <= '0;
      wr_addr_q   <= '0;
      page_num_q  <= '0;
      page_cnt_q  <= '0;
      counting_q  <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slice_q    <= slice_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      page_num_q <= page_num_d;
      page_cnt_q <= page_cnt_d;
      counting_q <= counting_d;
      cnt_q      <= cnt_d;
      ready_q    <= (cnt_d != 2'd2);
      done_q     <= done_d;
      err_q      <= err_d;
      if (push) begin
        fifo_data_q[wptr_q] <= asm_d;
        fifo_addr_q[wptr_q] <= addr_eff;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  assign msgIn_ready_o = ready_q;
  assign mem_wr_en_o   = (state_q == StWrite);
  assign mem_wr_addr_o = fifo_addr_q[rptr_q];
  assign mem_wr_data_o = fifo_data_q[rptr_q];
  assign layer_done_o  = done_q;
  assign err_partial_o = err_q;

endmodule

// File: tb/tb_l2pa_page_wr_buffer.sv
// Randomised bench for l2pa_page_wr_buffer: a queue-based page model checked every cycle,
// plus directed scenarios with literal address/data expectations.
module tb_l2pa_page_wr_buffer;

  localparam int W  = 20;
  localparam int PS = 3;
  localparam int PW = PS * W;
  localparam int AW = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  logic          sys_clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W-1:0]  msgIn_i = '0;
  logic          msgIn_valid_i = 1'b0;
  logic          msgIn_ready_o;
  logic          layer_start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW-1:0] page_num_i = '0;
  logic          mem_wr_en_o;
  logic          mem_wr_ready_i = 1'b0;
  logic [AW-1:0] mem_wr_addr_o;
  logic [PW-1:0] mem_wr_data_o;
  logic          layer_done_o;
  logic          err_partial_o;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: stall, 1: always ready, 2: random
  int done_seen = 0;

  wr_t          exp_q[$];
  wr_t          log_q[$];
  logic [W-1:0] beats_q[$];
  int           maddr, mnum, mcnt;
  bit           mcounting, merr, done_exp, skip;

  l2pa_page_wr_buffer dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .msgIn_i        (msgIn_i),
    .msgIn_valid_i  (msgIn_valid_i),
    .msgIn_ready_o  (msgIn_ready_o),
    .layer_start_i  (layer_start_i),
    .base_addr_i    (base_addr_i),
    .page_num_i     (page_num_i),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_wr_ready_i (mem_wr_ready_i),
    .mem_wr_addr_o  (mem_wr_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .layer_done_o   (layer_done_o),
    .err_partial_o  (err_partial_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_wr(input string nm, input int idx, input int addr, input logic [PW-1:0] data);
    if (idx >= log_q.size()) begin
      chk({nm, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
    end else begin
      chk({nm, "_addr"}, 64'(log_q[idx].addr), 64'(addr));
      chk({nm, "_data"}, 64'(log_q[idx].data), 64'(data));
    end
  endtask

  // Memory-side ready driver.
  initial forever begin
    @(posedge sys_clk);
    #1;
    case (rdy_mode)
      0:       mem_wr_ready_i = 1'b0;
      1:       mem_wr_ready_i = 1'b1;
      default: mem_wr_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and per-cycle comparison; updates reflect the upcoming posedge.
  initial begin
    skip = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!rstn) begin
        exp_q.delete();
        beats_q.delete();
        maddr = 0; mnum = 0; mcnt = 0;
        mcounting = 0; merr = 0; done_exp = 0; skip = 1;
      end else if (skip) begin
        skip = 0;
      end else begin
        bit acc;
        chk("ready", 64'(msgIn_ready_o), 64'(exp_q.size() < 2));
        chk("wr_en", 64'(mem_wr_en_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("wr_addr", 64'(mem_wr_addr_o), 64'(exp_q[0].addr));
          chk("wr_data", 64'(mem_wr_data_o), 64'(exp_q[0].data));
        end
        chk("layer_done", 64'(layer_done_o), 64'(done_exp));
        chk("err_partial", 64'(err_partial_o), 64'(merr));
        if (layer_done_o) done_seen++;
        done_exp = 0;
        acc = msgIn_valid_i && (exp_q.size() < 2);
        if (exp_q.size() != 0 && mem_wr_ready_i) begin
          wr_t w;
          w.addr = mem_wr_addr_o;
          w.data = mem_wr_data_o;
          log_q.push_back(w);
          void'(exp_q.pop_front());
          if (mcounting) begin
            mcnt++;
            if (mcnt == ((mnum == 0) ? 64 : mnum)) begin
              done_exp = 1; mcnt = 0; mcounting = 0;
            end
          end
        end
        if (layer_start_i) begin
          if (beats_q.size() != 0) merr = 1;
          beats_q.delete();
          maddr = int'(base_addr_i);
          mnum = int'(page_num_i);
          mcnt = 0;
          mcounting = 1;
        end
        if (acc) begin
          beats_q.push_back(msgIn_i);
          if (beats_q.size() == PS) begin
            wr_t p;
            p.addr = AW'(maddr);
            p.data = '0;
            for (int i = 0; i < PS; i++) p.data[i*W +: W] = beats_q[i];
            exp_q.push_back(p);
            beats_q.delete();
            maddr = (maddr + 1) % 64;
          end
        end
      end
    end
  end

  // All driving tasks start and end at posedge+1.
  task automatic send_beat(input logic [W-1:0] d);
    int n = 0;
    bit ok = 0;
    msgIn_i = d;
    msgIn_valid_i = 1'b1;
    while (!ok && n < 100) begin
      @(negedge sys_clk);
      ok = msgIn_ready_o;
      @(posedge sys_clk);
      #1;
      n++;
    end
    msgIn_valid_i = 1'b0;
    if (!ok) chk("beat_timeout", 64'(n), 64'(0));
  endtask

  task automatic layer_start(input int base, input int num);
    layer_start_i = 1'b1;
    base_addr_i = AW'(base);
    page_num_i = AW'(num);
    @(posedge sys_clk);
    #1;
    layer_start_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (mem_wr_en_o && n < 300);
    chk("drain_timeout", 64'(n < 300), 64'(1));
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
  endtask

  logic [W-1:0] lit [9];

  initial begin
    int idx, d0;
    for (int i = 0; i < 9; i++) lit[i] = W'(32'h10001 * (i + 1) + 32'h0A0A0 * i);

    // Reset state
    #12;
    chk("rst_ready", 64'(msgIn_ready_o), 64'(0));
    chk("rst_wr_en", 64'(mem_wr_en_o), 64'(0));
    chk("rst_addr", 64'(mem_wr_addr_o), 64'(0));
    chk("rst_data", 64'(mem_wr_data_o), 64'(0));
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("post_rst_ready", 64'(msgIn_ready_o), 64'(1));

    // Back-to-back fill, two-page layer at base 4
    rdy_mode = 1;
    layer_start(4, 2);
    log_q.delete();
    d0 = done_seen;
    for (int i = 0; i < 6; i++) send_beat(lit[i]);
    wait_drain();
    chk_wr("b2b0", 0, 4, {lit[2], lit[1], lit[0]});
    chk_wr("b2b1", 1, 5, {lit[5], lit[4], lit[3]});
    chk("b2b_done_cnt", 64'(done_seen - d0), 64'(1));

    // Backpressure: 20 stalled cycles, only two pages fit
    rdy_mode = 0;
    layer_start(20, 0);
    log_q.delete();
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      msgIn_i = lit[idx];
      msgIn_valid_i = 1'b1;
      @(negedge sys_clk);
      if (msgIn_ready_o) idx++;
      @(posedge sys_clk);
      #1;
    end
    msgIn_valid_i = 1'b0;
    chk("bp_accepted", 64'(idx), 64'(6));
    chk("bp_ready_low", 64'(msgIn_ready_o), 64'(0));
    rdy_mode = 1;
    for (int i = idx; i < 9; i++) send_beat(lit[i]);
    wait_drain();
    chk_wr("bp0", 0, 20, {lit[2], lit[1], lit[0]});
    chk_wr("bp2", 2, 22, {lit[8], lit[7], lit[6]});

    // Partial page dropped by a new layer
    send_beat(lit[0]);
    send_beat(lit[1]);
    log_q.delete();
    d0 = done_seen;
    layer_start(10, 1);
    for (int i = 3; i < 6; i++) send_beat(lit[i]);
    wait_drain();
    chk("partial_err", 64'(err_partial_o), 64'(1));
    chk_wr("partial", 0, 10, {lit[5], lit[4], lit[3]});
    chk("partial_done_cnt", 64'(done_seen - d0), 64'(1));

    // Address wrap
    layer_start(62, 3);
    log_q.delete();
    d0 = done_seen;
    for (int i = 0; i < 9; i++) send_beat(lit[i]);
    wait_drain();
    chk_wr("wrap0", 0, 62, {lit[2], lit[1], lit[0]});
    chk_wr("wrap1", 1, 63, {lit[5], lit[4], lit[3]});
    chk_wr("wrap2", 2, 0, {lit[8], lit[7], lit[6]});
    chk("wrap_done_cnt", 64'(done_seen - d0), 64'(1));

    // Randomised layers with random backpressure and gaps
    rdy_mode = 2;
    for (int l = 0; l < 4; l++) begin
      layer_start(int'($urandom_range(0, 63)), int'($urandom_range(1, 4)));
      for (int b = 0; b < 24; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge sys_clk);
          #1;
        end
        send_beat(W'($urandom));
      end
      wait_drain();
    end

    // Reset while a write is pending
    rdy_mode = 0;
    layer_start(30, 1);
    for (int i = 0; i < 3; i++) send_beat(lit[i]);
    chk("pre_rst_wr_en", 64'(mem_wr_en_o), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_wr_en", 64'(mem_wr_en_o), 64'(0));
    chk("arst_ready", 64'(msgIn_ready_o), 64'(0));
    chk("arst_addr", 64'(mem_wr_addr_o), 64'(0));
    chk("arst_data", 64'(mem_wr_data_o), 64'(0));
    chk("arst_err", 64'(err_partial_o), 64'(0));
    chk("arst_done", 64'(layer_done_o), 64'(0));
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("rel_ready", 64'(msgIn_ready_o), 64'(1));
    rdy_mode = 1;
    log_q.delete();
    for (int i = 6; i < 9; i++) send_beat(lit[i]);
    wait_drain();
    chk("rel_writes", 64'(log_q.size()), 64'(1));
    chk_wr("rel", 0, 0, {lit[8], lit[7], lit[6]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
